// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between instruction
// fetch and the memory-access stage. Data requests normally win; a fetch is
// forced through after STARVE_MAX consecutive data grants while it waits.
// No grant is made in a cycle where a valid pulse is being returned, because
// the requester that completed still shows its request in that cycle.
// Optional feature: define ARB_PERF_CNT_EN to add the wait-cycle counters
// perf_if_wait and perf_ma_wait.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [31:0]       ma_wdata,
    input  logic [3:0]        ma_be,
    output logic [31:0]       ma_rdata,
    output logic              ma_valid,
    output logic              ma_stall,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_ma_wait,
`endif
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        FETCH        = 2'd1,
        DATA         = 2'd2,
        FETCH_KILLED = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       grant_fetch;
    logic       grant_data;
    logic       deliver_if;
    logic       deliver_ma;
    logic [3:0] starve_cnt;

    assign if_stall = if_req & ~if_valid & ~if_kill;
    assign ma_stall = ma_req & ~ma_valid;

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, transaction sequencing and delivery decisions.
    always_comb begin
        state_next  = state;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        deliver_if  = 1'b0;
        deliver_ma  = 1'b0;
        case (state)
            IDLE: begin
                if (!if_valid && !ma_valid) begin
                    if (if_req && !if_kill && (!ma_req || starve_cnt == STARVE_LIM)) begin
                        grant_fetch = 1'b1;
                        state_next  = FETCH;
                    end else if (ma_req) begin
                        grant_data = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            FETCH: begin
                if (bus_ack) begin
                    deliver_if = ~if_kill;
                    state_next = IDLE;
                end else if (if_kill) begin
                    state_next = FETCH_KILLED;
                end
            end
            FETCH_KILLED: begin
                if (bus_ack) begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                if (bus_ack) begin
                    deliver_ma = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Count data grants that overtake a waiting fetch, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!if_req || grant_fetch) begin
            starve_cnt <= 4'd0;
        end else if (grant_data && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Bus registers: loaded on grant, held stable for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
        end else begin
            bus_req <= (state_next != IDLE);
            if (grant_fetch) begin
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= 32'd0;
                bus_be    <= 4'hF;
            end else if (grant_data) begin
                bus_we    <= ma_we;
                bus_addr  <= ma_addr;
                bus_wdata <= ma_wdata;
                bus_be    <= ma_be;
            end
        end
    end

    // Return path: capture read data and pulse the completion valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= 32'd0;
            if_valid <= 1'b0;
            ma_rdata <= 32'd0;
            ma_valid <= 1'b0;
        end else begin
            if_valid <= deliver_if;
            ma_valid <= deliver_ma;
            if (deliver_if) begin
                if_rdata <= bus_rdata;
            end
            if (deliver_ma && !bus_we) begin
                ma_rdata <= bus_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Wait-cycle counters for each requester; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_wait <= 32'd0;
            perf_ma_wait <= 32'd0;
        end else begin
            if (if_stall) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end
            if (ma_stall) begin
                perf_ma_wait <= perf_ma_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_MAX = 2).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_kill, ma_req, ma_we, bus_ack;
    logic [31:0] if_addr, ma_addr, ma_wdata, bus_rdata;
    logic [3:0]  ma_be;
    logic [31:0] if_rdata, ma_rdata, bus_addr, bus_wdata;
    logic        if_valid, if_stall, ma_valid, ma_stall, bus_req, bus_we;
    logic [3:0]  bus_be;

    int checks = 0;
    int fails  = 0;

    mem_port_arbiter #(.STARVE_MAX(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_be(ma_be), .ma_rdata(ma_rdata), .ma_valid(ma_valid), .ma_stall(ma_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [5:0] order;   // 1 = fetch grant expected, bit i for grant i

    initial begin
        rst_n = 1'b0; if_req = 0; if_kill = 0; if_addr = 0;
        ma_req = 0; ma_we = 0; ma_addr = 0; ma_wdata = 0; ma_be = 0;
        bus_ack = 0; bus_rdata = 0;
        tick(); tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_ma_valid", ma_valid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        rst_n = 1'b1;
        tick();

        // Single fetch, ack in the second bus cycle
        if_req = 1; if_addr = 32'h100;
        #1 chk("f1_stall_pre", if_stall, 1);
        tick();
        chk("f1_bus_req", bus_req, 1);
        chk("f1_bus_addr", bus_addr, 32'h100);
        chk("f1_bus_be", bus_be, 4'hF);
        chk("f1_bus_we", bus_we, 0);
        tick();
        chk("f1_no_valid_yet", if_valid, 0);
        chk("f1_stall_wait", if_stall, 1);
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 0;
        chk("f1_if_valid", if_valid, 1);
        chk("f1_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("f1_stall_done", if_stall, 0);
        chk("f1_bus_drop", bus_req, 0);
        if_req = 0;
        tick();
        chk("f1_valid_pulse", if_valid, 0);

        // Simultaneous requests with zero-wait acks: data first, then fetch
        if_req = 1; if_addr = 32'h200;
        ma_req = 1; ma_we = 0; ma_addr = 32'h8000;
        bus_ack = 1; bus_rdata = 32'h11111111;
        tick();
        chk("sim_d_addr", bus_addr, 32'h8000);
        chk("sim_d_we", bus_we, 0);
        tick();
        chk("sim_ma_valid", ma_valid, 1);
        chk("sim_ma_rdata", ma_rdata, 32'h11111111);
        chk("sim_ma_stall", ma_stall, 0);
        chk("sim_bus_idle", bus_req, 0);
        ma_req = 0; bus_rdata = 32'h22222222;
        tick();
        chk("sim_idle_gap", bus_req, 0);
        chk("sim_ma_pulse", ma_valid, 0);
        tick();
        chk("sim_f_req", bus_req, 1);
        chk("sim_f_addr", bus_addr, 32'h200);
        tick();
        chk("sim_if_valid", if_valid, 1);
        chk("sim_if_rdata", if_rdata, 32'h22222222);
        if_req = 0; bus_ack = 0;
        tick();

        // Starvation limit 2: grant order D, D, F, D, D, F
        order = 6'b100100;
        if_req = 1; if_addr = 32'h500;
        ma_req = 1; ma_we = 0; ma_addr = 32'h600;
        bus_ack = 1; bus_rdata = 32'h33333333;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("stv_req_%0d", i), bus_req, 1);
            chk($sformatf("stv_addr_%0d", i), bus_addr, order[i] ? 32'h500 : 32'h600);
            tick();
            chk($sformatf("stv_ifv_%0d", i), if_valid, order[i] ? 1 : 0);
            chk($sformatf("stv_mav_%0d", i), ma_valid, order[i] ? 0 : 1);
            if (i == 5) begin
                if_req = 0; ma_req = 0; bus_ack = 0;
            end
            tick();
            chk($sformatf("stv_gap_%0d", i), bus_req, 0);
        end

        // Kill mid-fetch with ack withheld for three cycles
        if_req = 1; if_addr = 32'h300;
        tick();
        chk("kill_addr", bus_addr, 32'h300);
        if_kill = 1;
        #1 chk("kill_stall", if_stall, 0);
        tick();
        if_kill = 0; if_addr = 32'h400;
        chk("kill_hold1", bus_req, 1);
        tick();
        chk("kill_hold2", bus_req, 1);
        chk("kill_addr_stable", bus_addr, 32'h300);
        bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
        tick();
        bus_ack = 0;
        chk("kill_no_valid", if_valid, 0);
        chk("kill_rdata_kept", if_rdata, 32'h33333333);
        chk("kill_bus_drop", bus_req, 0);
        tick();
        chk("refetch_addr", bus_addr, 32'h400);
        chk("refetch_req", bus_req, 1);
        bus_ack = 1; bus_rdata = 32'h12345678;
        tick();
        chk("refetch_valid", if_valid, 1);
        chk("refetch_rdata", if_rdata, 32'h12345678);
        if_req = 0; bus_ack = 0;
        tick();

        // Kill in the same cycle as ack: data discarded
        if_req = 1; if_addr = 32'h700;
        tick();
        if_kill = 1; bus_ack = 1; bus_rdata = 32'h77777777;
        tick();
        if_kill = 0; bus_ack = 0; if_req = 0;
        chk("killack_no_valid", if_valid, 0);
        chk("killack_rdata", if_rdata, 32'h12345678);
        chk("killack_bus_drop", bus_req, 0);
        tick();

        // Write: bus mirrors all fields, ma_rdata holds
        ma_req = 1; ma_we = 1; ma_addr = 32'h10; ma_wdata = 32'hCAFEF00D; ma_be = 4'b0011;
        tick();
        chk("wr_we", bus_we, 1);
        chk("wr_addr", bus_addr, 32'h10);
        chk("wr_wdata", bus_wdata, 32'hCAFEF00D);
        chk("wr_be", bus_be, 4'b0011);
        chk("wr_stall", ma_stall, 1);
        bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
        tick();
        chk("wr_valid", ma_valid, 1);
        chk("wr_rdata_kept", ma_rdata, 32'h33333333);
        ma_req = 0; ma_we = 0; bus_ack = 0;
        tick();
        chk("wr_valid_pulse", ma_valid, 0);

        // Asynchronous reset in the middle of a data transaction
        ma_req = 1; ma_addr = 32'h20; ma_be = 4'hF;
        tick();
        chk("rstm_active", bus_req, 1);
        #2 rst_n = 0; ma_req = 0;
        #1;
        chk("rstm_bus_req", bus_req, 0);
        chk("rstm_bus_addr", bus_addr, 0);
        chk("rstm_bus_be", bus_be, 0);
        chk("rstm_ma_rdata", ma_rdata, 0);
        chk("rstm_if_rdata", if_rdata, 0);
        tick();
        #2 rst_n = 1;
        tick();
        chk("rstm_idle", bus_req, 0);
        ma_req = 1; ma_addr = 32'h24; bus_ack = 1; bus_rdata = 32'h0BADF00D;
        tick();
        chk("post_rst_addr", bus_addr, 32'h24);
        tick();
        chk("post_rst_valid", ma_valid, 1);
        chk("post_rst_rdata", ma_rdata, 32'h0BADF00D);
        ma_req = 0; bus_ack = 0;
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory bus between the instruction fetch stage and the memory-access stage of the 5-stage core.
- Arbitrates between the two requesters, sequences each bus transaction through a small FSM, and returns data with a one-cycle valid pulse.
- Drives the fetch and memory-access stall signals that the hazard logic consumes.
- Discards in-flight fetches when a branch or jump redirect occurs.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch waits before fetch is forced; range 1..15.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_valid or if_kill
- if_addr  in  ADDR_W  fetch address (pc); stable while if_req high
- if_kill  in  1  redirect (ex_pc_src); cancels pending or in-flight fetch
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle pulse; if_rdata is valid
- if_stall  out  1  fetch waiting
- ma_req  in  1  data request; held until ma_valid
- ma_we  in  1  1 = write
- ma_addr  in  ADDR_W  data address
- ma_wdata  in  32  write data
- ma_be  in  4  byte enables
- ma_rdata  out  32  load data
- ma_valid  out  1  one-cycle completion pulse (reads and writes)
- ma_stall  out  1  memory stage waiting
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  32  bus write data
- bus_be  out  4  bus byte enables (4'hF for fetch)
- bus_rdata  in  32  bus read data, valid with bus_ack
- bus_ack  in  1  transaction complete; may arrive in the first bus_req cycle

Behaviour:
- Clocking: single clock domain clk.
- Reset: rst_n is asynchronous and active-low. Reset forces state IDLE, starve_cnt=0, and every output to 0.
- States: IDLE, FETCH, DATA, FETCH_KILLED.
- IDLE arbitration, registered on the clk edge:
  - if_kill high: fetch is not eligible this cycle.
  - Otherwise ma_req wins over if_req.
  - Exception: if if_req is high and starve_cnt==STARVE_MAX, fetch wins.
- Grant actions:
  - Latch the address, we, wdata and be into the bus registers.
  - Fetch grant: bus_we=0, bus_be=4'hF.
  - bus_req=1 from the next cycle.
- FETCH:
  - bus_ack: if_rdata<=bus_rdata, if_valid=1 for one cycle, go to IDLE.
  - if_kill without bus_ack: go to FETCH_KILLED.
  - if_kill with bus_ack in the same cycle: data is discarded, no if_valid, go to IDLE.
- FETCH_KILLED: bus_req stays high (the bus is never abandoned). On bus_ack, discard the data, no if_valid, go to IDLE.
- DATA: on bus_ack go to IDLE and pulse ma_valid. ma_rdata<=bus_rdata only for reads; on writes ma_rdata holds its value. if_kill has no effect in DATA.
- Bus hold: bus_req drops in the cycle after bus_ack. IDLE lasts at least one cycle between transactions. Minimum latency is request to valid in 2 cycles (grant, ack).
- starve_cnt:
  - Increments on each data grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on a fetch grant or whenever if_req=0.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid & ~if_kill.
  - ma_stall = ma_req & ~ma_valid.
- Bus outputs are registered and stable while bus_req=1.
- Reset mid-transaction: immediate IDLE with bus_req=0. The bus slave must also be reset by rst_n.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs perf_if_wait (32) and perf_ma_wait (32), both cleared by reset.
  - perf_if_wait increments each cycle if_stall=1; perf_ma_wait increments each cycle ma_stall=1.
  - Both counters wrap at 2^32.
- Without the macro: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; bus_ack one cycle after bus_req rises, bus_rdata=0xDEADBEEF. Expect bus_addr=0x100, bus_be=4'hF, bus_we=0, and if_valid for exactly one cycle with if_rdata=0xDEADBEEF. if_stall is high until the if_valid cycle.
- Simultaneous requests: if_req (0x200) and ma_req read (0x8000) in the same cycle, zero-wait acks. Expect the data transaction first (ma_valid), one IDLE cycle, then the fetch of 0x200.
- Starvation, STARVE_MAX=2: if_req held high; ma_req re-asserted every cycle after each ma_valid. Expect grant order D, D, F, D, D, F.
- Kill mid-fetch: fetch 0x300 granted; if_kill pulses while bus_ack is withheld 3 cycles. Expect bus_req held until ack and no if_valid. A following fetch of 0x400 completes normally.
- Write: ma_we=1, ma_addr=0x10, ma_wdata=0xCAFEF00D, ma_be=4'b0011. Expect the bus to mirror all fields, ma_valid to pulse, and ma_rdata to keep its prior value.
- Reset mid-DATA: rst_n low asynchronously while bus_req=1. Expect bus_req=0 and all outputs 0 before the next clk edge; after release the block is IDLE.
